// File: rtl/wide_compare_pkg.sv
// Shared definitions for the sequential wide magnitude comparator.
//   state_t     : FSM encoding {IDLE, RUN, DONE}
//   NIB_W       : width of one compared slice (one nibble)
//   idx_width() : bits needed for a nibble index, never less than 1
package wide_compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparator4bit.sv
// Combinational 4-bit unsigned magnitude comparator.
//   a, b       : operands
//   lt, eq, gt : one-hot relation of a to b
module comparator4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule

// File: rtl/wide_compare_seq.sv
// Sequential magnitude comparator for W = 4*NIBBLES bit unsigned operands.
// One nibble is compared per clock, MSB first, stopping at the first
// unequal nibble, so a single comparator4bit serves any operand width.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start_valid/ready : request handshake; a_in/b_in sampled on handshake
//   res_valid/ready   : result handshake; lt/eq/gt/diff_idx valid with res_valid
//   diff_idx          : index of the deciding nibble (0 = LS nibble, 0 if equal)
//   dbg_state_o       : current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. ready/valid outputs depend only on registered state and rst_n,
// never combinationally on the partner's valid/ready.
module wide_compare_seq
    import wide_compare_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = NIB_W * NIBBLES,
    localparam int IW     = idx_width(NIBBLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          lt,
    output logic          eq,
    output logic          gt,
    output logic [IW-1:0] diff_idx,
    output logic [1:0]    dbg_state_o
);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;
    logic [IW-1:0] diff_q, diff_d;

    logic [NIB_W-1:0] a_nib, b_nib;
    logic             cmp_lt, cmp_eq, cmp_gt;

    // Nibble select mux: the slice under test is addressed by the pointer.
    assign a_nib = a_q[{idx_q, 2'b00} +: NIB_W];
    assign b_nib = b_q[{idx_q, 2'b00} +: NIB_W];

    comparator4bit u_cmp (
        .a  (a_nib),
        .b  (b_nib),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        diff_d  = diff_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = IW'(NIBBLES - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!cmp_eq) begin
                    lt_d    = cmp_lt;
                    gt_d    = cmp_gt;
                    eq_d    = 1'b0;
                    diff_d  = idx_q;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    diff_d  = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    // Flags are cleared on exit; diff_idx keeps its value.
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            diff_q  <= diff_d;
        end
    end

    // Reset forces the handshake outputs low even before the reset edge.
    assign start_ready = rst_n && (state_q == IDLE);
    assign res_valid   = rst_n && (state_q == DONE);
    assign lt          = res_valid && lt_q;
    assign eq          = res_valid && eq_q;
    assign gt          = res_valid && gt_q;
    assign diff_idx    = diff_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wide_compare_seq.sv
module tb_wide_compare_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT, NIBBLES=4 ----------------
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        lt, eq, gt;
  logic [1:0]  diff_idx;
  logic [1:0]  dbg_state;

  wide_compare_seq #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt),
    .diff_idx    (diff_idx),
    .dbg_state_o (dbg_state)
  );

  // ---------------- DUT, NIBBLES=1 ----------------
  logic       start_valid1 = 1'b0;
  logic       start_ready1;
  logic [3:0] a_in1 = '0;
  logic [3:0] b_in1 = '0;
  logic       res_valid1;
  logic       res_ready1 = 1'b0;
  logic       lt1, eq1, gt1;
  logic [0:0] diff_idx1;
  logic [1:0] dbg_state1;

  wide_compare_seq #(.NIBBLES(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid1),
    .start_ready (start_ready1),
    .a_in        (a_in1),
    .b_in        (b_in1),
    .res_valid   (res_valid1),
    .res_ready   (res_ready1),
    .lt          (lt1),
    .eq          (eq1),
    .gt          (gt1),
    .diff_idx    (diff_idx1),
    .dbg_state_o (dbg_state1)
  );

  // ---------------- scoreboard ----------------
  // Packed expectation: {latency[3:0], diff_idx[1:0], gt, eq, lt}
  localparam int EW = 9;
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic l, input logic e, input logic g,
                                             input logic [1:0] d, input int lat);
    return {lat[3:0], d, g, e, l};
  endfunction

  // Independent reference: relation from full-width compare, deciding
  // nibble = highest nibble where the operands differ.
  function automatic logic [EW-1:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [1:0] d;
    int lat;
    logic [15:0] x;
    x = a ^ b;
    d = 2'd0;
    for (int i = 0; i < 4; i++)
      if (x[4*i +: 4] != 4'h0) d = i[1:0];
    lat = (a == b) ? 4 : 4 - int'(d);
    return pack_exp(a < b, a == b, a > b, d, lat);
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit inject);
    int waitc;
    int lat;
    bit seen;
    logic [EW-1:0] e;
    waitc = 0;
    while (!start_ready && waitc < 20) begin
      @(posedge clk); @(negedge clk); waitc++;
    end
    check("start_ready_idle", start_ready, 1);
    a_in = a; b_in = b; start_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    start_valid = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom);
    check("start_ready_busy", start_ready, 0);
    lat = 1; seen = 1'b0;
    while (lat <= 20) begin
      @(posedge clk); @(negedge clk);
      if (res_valid) begin seen = 1'b1; break; end
      lat++;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check("res_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, e[8:5]);
    check("lt", lt, e[0]);
    check("eq", eq, e[1]);
    check("gt", gt, e[2]);
    check("diff_idx", diff_idx, e[4:3]);
    for (int i = 0; i < hold; i++) begin
      if (inject && i == 1) begin
        start_valid = 1'b1; a_in = 16'h5555; b_in = 16'h5555;
      end
      @(posedge clk); @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_start_ready", start_ready, 0);
      check("hold_flags", {gt, eq, lt}, e[2:0]);
      check("hold_diff_idx", diff_idx, e[4:3]);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    check("idle_after_accept", start_ready, 1);
    check("res_valid_dropped", res_valid, 0);
    check("flags_cleared", {gt, eq, lt}, 3'b000);
    check("diff_idx_kept", diff_idx, e[4:3]);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        lt;
    logic        eq;
    logic        gt;
    logic [1:0]  diff;
    int          lat;
    int          hold;
    bit          inject;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] ra, rb;
    int waitc;
    logic [2:0] e1;

    vecs[0] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd0, 4, 0, 1'b0};
    vecs[1] = '{16'h2000, 16'h1FFF, 1'b0, 1'b0, 1'b1, 2'd3, 1, 0, 1'b0};
    vecs[2] = '{16'h12A4, 16'h12A7, 1'b1, 1'b0, 1'b0, 2'd0, 4, 0, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 2'd3, 1, 5, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b1, 2'd0, 4, 0, 1'b0};
    vecs[5] = '{16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0, 2'd2, 2, 2, 1'b0};
    vecs[6] = '{16'hABCD, 16'hAB0D, 1'b0, 1'b0, 1'b1, 2'd1, 3, 0, 1'b0};

    // Reset phase
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_start_ready", start_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_flags", {gt, eq, lt}, 3'b000);
    repeat (2) @(negedge clk);
    check("rst_diff_idx", diff_idx, 0);
    check("rst_start_ready1", start_ready1, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_start_ready", start_ready, 1);
    check("post_rst_res_valid", res_valid, 0);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(pack_exp(vecs[i].lt, vecs[i].eq, vecs[i].gt, vecs[i].diff, vecs[i].lat));
      run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].inject);
    end

    // Reset in the middle of RUN
    a_in = 16'h1111; b_in = 16'h1112; start_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    start_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("mid_run_no_result", res_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_start_ready", start_ready, 0);
    check("mid_rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("after_mid_rst_ready", start_ready, 1);
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      check("abandoned_no_result", res_valid, 0);
    end
    exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b1, 2'd1, 3));
    run_op(16'h0010, 16'h0001, 0, 1'b0);

    // Random operands, some with forced equal upper nibbles
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) rb = {ra[15:8], rb[7:0]};
      if (i % 5 == 0) rb = ra;
      exp_q.push_back(model(ra, rb));
      run_op(ra, rb, $urandom_range(0, 2), 1'b0);
    end

    // NIBBLES=1 instance
    for (int k = 0; k < 2; k++) begin
      a_in1 = (k == 0) ? 4'b1010 : 4'b0101;
      b_in1 = (k == 0) ? 4'b0011 : 4'b0101;
      e1 = (k == 0) ? 3'b100 : 3'b010;
      check("n1_start_ready", start_ready1, 1);
      start_valid1 = 1'b1;
      @(posedge clk); @(negedge clk);
      start_valid1 = 1'b0;
      check("n1_not_yet", res_valid1, 0);
      waitc = 0;
      @(posedge clk); @(negedge clk);
      while (!res_valid1 && waitc < 10) begin
        @(posedge clk); @(negedge clk); waitc++;
      end
      check("n1_latency_1", waitc, 0);
      check("n1_flags", {gt1, eq1, lt1}, e1);
      check("n1_diff_idx", diff_idx1, 0);
      res_ready1 = 1'b1;
      @(posedge clk); @(negedge clk);
      res_ready1 = 1'b0;
      check("n1_idle", start_ready1, 1);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wide_compare_seq.md
# wide_compare_seq

Sequential magnitude comparator for wide unsigned operands built around one `comparator4bit` instance. It compares MSB-first, one nibble per clock, and terminates early at the first unequal nibble. It sits between a requester and a consumer, with a valid/ready handshake on each side. It lets a single 4-bit comparator serve operands of any width `4*NIBBLES`.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; legal values are 1 and up. Operand width W = 4*NIBBLES.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start_valid` in 1: request to compare `a_in`/`b_in`.
- `start_ready` out 1: block can accept a request (IDLE and `rst_n`=1).
- `a_in` in W: operand A, unsigned; sampled only on start handshake.
- `b_in` in W: operand B, unsigned; sampled only on start handshake.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `lt` out 1: A < B; valid only with `res_valid`.
- `eq` out 1: A == B; valid only with `res_valid`.
- `gt` out 1: A > B; valid only with `res_valid`.
- `diff_idx` out IW=max(1,clog2(NIBBLES)): index of the deciding nibble. 0 = least significant. Equal result reports 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start_ready`=1.
  - Start handshake (`start_valid`&&`start_ready`): latch A and B into operand registers, set nibble pointer `idx`=NIBBLES-1, go to RUN.
- **RUN**
  - Comparator inputs are `a_reg[4*idx+:4]` and `b_reg[4*idx+:4]`.
  - Comparator `lt` or `gt`: register the result flags and `diff_idx`=`idx`, go to DONE.
  - Comparator `eq` and `idx`==0: register `eq`=1 and `diff_idx`=0, go to DONE.
  - Comparator `eq` and `idx`>0: decrement `idx`, stay in RUN.
- **DONE**
  - `res_valid`=1; exactly one of `lt`/`eq`/`gt` is high.
  - On `res_ready`=1, go to IDLE.
  - While `res_ready`=0, every output is held stable.
- Outside DONE, `lt`/`eq`/`gt` are all 0; `diff_idx` is 0 after reset and otherwise keeps its last value.
- Arithmetic is unsigned, with no sign extension. `idx` never wraps below 0, because RUN exits at `idx`==0.
- `start_valid` is ignored in RUN and DONE. Operands presented then are not sampled.
- `res_ready` is ignored outside DONE.
- NIBBLES=1: RUN lasts exactly one cycle; `diff_idx` is a 1-bit constant 0.

## Timing
- Reset: `rst_n`=0 at an edge drives the FSM to IDLE and clears `idx`, the result registers and `diff_idx`.
  - While `rst_n`=0, `start_ready`=0, `res_valid`=0, and `lt`/`eq`/`gt`=0.
  - Reset asserted in RUN or DONE abandons the operation; no result is produced.
- Start accepted at edge E0 → RUN. The comparison of nibble k' (counting from the MSB, k'=1..NIBBLES) completes at edge E(k').
- Deciding nibble at position k (counted from the MSB): `res_valid` rises after edge Ek. Latency is k cycles, minimum 1 and maximum NIBBLES.
- Result accepted at edge Er → IDLE; `start_ready`=1 in the cycle after Er.
  - No same-edge DONE→RUN chaining.
  - Best-case throughput is one operation per k+2 cycles.
- The comparator path is combinational from `a_reg`/`b_reg`/`idx` to the result registers. There is no comparator output registering beyond the result flops.
- `start_ready`, `res_valid`, `lt`/`eq`/`gt` and `diff_idx` depend only on registered state and `rst_n`. There is no combinational path from `start_valid` or `res_ready` to outputs.

## Structure
- Shared package `wide_compare_pkg`:
  - state enum `{IDLE, RUN, DONE}`;
  - constant `NIB_W`=4;
  - function `idx_width(n)` = max(1,clog2(n)).
- Single sub-module: the existing `comparator4bit` (`a`, `b`, `lt`, `eq`, `gt`), instantiated once and unmodified.
- Top level contains the FSM, operand registers, nibble pointer, result registers and the nibble select mux.

## Test plan
All cases use NIBBLES=4 unless stated.
- `a_in`=16'h1234, `b_in`=16'h1234 → `eq`=1, `diff_idx`=0, `res_valid` 4 cycles after accept.
- `a_in`=16'h2000, `b_in`=16'h1FFF → `gt`=1, `diff_idx`=3, latency 1 cycle.
- `a_in`=16'h12A4, `b_in`=16'h12A7 → `lt`=1, `diff_idx`=0, latency 4 cycles.
- Backpressure: 16'h0000 vs 16'hFFFF with `res_ready`=0 for 5 cycles.
  - `lt`=1 and `diff_idx`=3 stay stable throughout; `start_ready`=0.
  - A new `start_valid` with 16'h5555/16'h5555 during the wait is ignored.
  - After `res_ready`=1, IDLE in the next cycle.
- Reset mid-RUN:
  - Start 16'h1111 vs 16'h1112; drop `rst_n` for one edge after 2 RUN cycles. Expect `res_valid`=0, `start_ready`=0 during reset, then `start_ready`=1.
  - Then compare 16'h0010 vs 16'h0001 → `gt`=1, `diff_idx`=1, latency 3 cycles.
- NIBBLES=1 instance: 4'b1010 vs 4'b0011 → `gt`=1, `diff_idx`=0, latency 1 cycle.
